// File: rtl/mem_stage_module.sv
// MEM stage: issues one req/ack data-memory access per load/store and loads the MEM/WB register.
// Latency 1 cycle for non-memory ops, >=2 for memory ops; mem_stall holds upstream until ack, freeze holds all.
module mem_stage_module #(
    parameter int ADDRESS_LEN = 32,
    parameter int DATA_LEN    = 32,
    parameter int MEM_BASE    = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   freeze,
    input  logic                   valid_in,
    input  logic [ADDRESS_LEN-1:0] pc_in,
    input  logic                   wb_en_in,
    input  logic                   mem_r_en_in,
    input  logic                   mem_w_en_in,
    input  logic [DATA_LEN-1:0]    alu_res_in,
    input  logic [DATA_LEN-1:0]    val_rm_in,
    input  logic [3:0]             dest_in,
    output logic                   mem_req,
    output logic                   mem_we,
    output logic [ADDRESS_LEN-1:0] mem_addr,
    output logic [DATA_LEN-1:0]    mem_wdata,
    input  logic [DATA_LEN-1:0]    mem_rdata,
    input  logic                   mem_ack,
    output logic                   mem_stall,
    output logic                   valid_out,
    output logic [ADDRESS_LEN-1:0] pc_out,
    output logic                   wb_en_out,
    output logic                   mem_r_en_out,
    output logic [DATA_LEN-1:0]    alu_res_out,
    output logic [DATA_LEN-1:0]    mem_data_out,
    output logic [3:0]             dest_out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [ADDRESS_LEN-1:0] BASE_ADDR = ADDRESS_LEN'(MEM_BASE);

    state_t                 state_q, state_d;
    logic [ADDRESS_LEN-1:0] addr_q, addr_d;
    logic                   we_q, we_d;
    logic [DATA_LEN-1:0]    wdata_q, wdata_d;
    logic [DATA_LEN-1:0]    hold_q, hold_d;
    logic                   valid_out_q, valid_out_d;
    logic [ADDRESS_LEN-1:0] pc_out_q, pc_out_d;
    logic                   wb_en_out_q, wb_en_out_d;
    logic                   mem_r_en_out_q, mem_r_en_out_d;
    logic [DATA_LEN-1:0]    alu_res_out_q, alu_res_out_d;
    logic [DATA_LEN-1:0]    mem_data_out_q, mem_data_out_d;
    logic [3:0]             dest_out_q, dest_out_d;

    logic                   memop;
    logic                   is_store;
    logic [ADDRESS_LEN-1:0] byte_off;
    logic [ADDRESS_LEN-1:0] issue_addr;
    logic                   load_wb;
    logic [DATA_LEN-1:0]    load_data;

    // A load/store with both enables set behaves as a load.
    assign memop      = valid_in & (mem_r_en_in | mem_w_en_in);
    assign is_store   = mem_w_en_in & ~mem_r_en_in;
    assign byte_off   = ADDRESS_LEN'(alu_res_in) - BASE_ADDR;
    assign issue_addr = byte_off & ~(ADDRESS_LEN'(3));

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        we_d           = we_q;
        wdata_d        = wdata_q;
        hold_d         = hold_q;
        valid_out_d    = valid_out_q;
        pc_out_d       = pc_out_q;
        wb_en_out_d    = wb_en_out_q;
        mem_r_en_out_d = mem_r_en_out_q;
        alu_res_out_d  = alu_res_out_q;
        mem_data_out_d = mem_data_out_q;
        dest_out_d     = dest_out_q;
        mem_req        = 1'b0;
        mem_we         = 1'b0;
        mem_addr       = '0;
        mem_wdata      = '0;
        mem_stall      = 1'b0;
        load_wb        = 1'b0;
        load_data      = '0;

        case (state_q)
            S_IDLE: begin
                if (memop) begin
                    mem_stall = 1'b1;
                    if (!freeze) begin
                        mem_req   = 1'b1;
                        mem_we    = is_store;
                        mem_addr  = issue_addr;
                        mem_wdata = val_rm_in;
                        addr_d    = issue_addr;
                        we_d      = is_store;
                        wdata_d   = val_rm_in;
                        state_d   = S_WAIT;
                    end
                end else if (!freeze) begin
                    load_wb = 1'b1;
                end
            end
            S_WAIT: begin
                mem_req   = 1'b1;
                mem_we    = we_q;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                if (mem_ack) begin
                    if (!freeze) begin
                        load_wb   = 1'b1;
                        load_data = we_q ? '0 : mem_rdata;
                        state_d   = S_IDLE;
                    end else begin
                        // Ack under freeze: park the read data until the pipeline moves again.
                        hold_d  = we_q ? '0 : mem_rdata;
                        state_d = S_DONE;
                    end
                end else begin
                    mem_stall = 1'b1;
                end
            end
            S_DONE: begin
                if (!freeze) begin
                    load_wb   = 1'b1;
                    load_data = hold_q;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (!freeze) begin
            if (load_wb) begin
                valid_out_d    = valid_in;
                pc_out_d       = pc_in;
                wb_en_out_d    = valid_in & wb_en_in;
                mem_r_en_out_d = valid_in & mem_r_en_in;
                alu_res_out_d  = alu_res_in;
                mem_data_out_d = load_data;
                dest_out_d     = dest_in;
            end else begin
                valid_out_d    = 1'b0;
                wb_en_out_d    = 1'b0;
                mem_r_en_out_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            addr_q         <= '0;
            we_q           <= 1'b0;
            wdata_q        <= '0;
            hold_q         <= '0;
            valid_out_q    <= 1'b0;
            pc_out_q       <= '0;
            wb_en_out_q    <= 1'b0;
            mem_r_en_out_q <= 1'b0;
            alu_res_out_q  <= '0;
            mem_data_out_q <= '0;
            dest_out_q     <= '0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            we_q           <= we_d;
            wdata_q        <= wdata_d;
            hold_q         <= hold_d;
            valid_out_q    <= valid_out_d;
            pc_out_q       <= pc_out_d;
            wb_en_out_q    <= wb_en_out_d;
            mem_r_en_out_q <= mem_r_en_out_d;
            alu_res_out_q  <= alu_res_out_d;
            mem_data_out_q <= mem_data_out_d;
            dest_out_q     <= dest_out_d;
        end
    end

    assign valid_out    = valid_out_q;
    assign pc_out       = pc_out_q;
    assign wb_en_out    = wb_en_out_q;
    assign mem_r_en_out = mem_r_en_out_q;
    assign alu_res_out  = alu_res_out_q;
    assign mem_data_out = mem_data_out_q;
    assign dest_out     = dest_out_q;

endmodule

// File: tb/tb_mem_stage_module.sv
// Bench for mem_stage_module: directed scenarios plus a randomized instruction stream
// checked against an in-order pipeline/memory reference model.
module tb_mem_stage_module;

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic        wb;
        logic        r;
        logic        w;
        logic [31:0] alu;
        logic [31:0] rm;
        logic [3:0]  dest;
    } instr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze;
    logic        valid_in;
    logic [31:0] pc_in;
    logic        wb_en_in;
    logic        mem_r_en_in;
    logic        mem_w_en_in;
    logic [31:0] alu_res_in;
    logic [31:0] val_rm_in;
    logic [3:0]  dest_in;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        mem_stall;
    logic        valid_out;
    logic [31:0] pc_out;
    logic        wb_en_out;
    logic        mem_r_en_out;
    logic [31:0] alu_res_out;
    logic [31:0] mem_data_out;
    logic [3:0]  dest_out;

    int checks = 0;
    int errors = 0;

    mem_stage_module #(.ADDRESS_LEN(32), .DATA_LEN(32), .MEM_BASE(1024)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .valid_in(valid_in), .pc_in(pc_in),
        .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
        .alu_res_in(alu_res_in), .val_rm_in(val_rm_in), .dest_in(dest_in),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_stall(mem_stall),
        .valid_out(valid_out), .pc_out(pc_out), .wb_en_out(wb_en_out),
        .mem_r_en_out(mem_r_en_out), .alu_res_out(alu_res_out),
        .mem_data_out(mem_data_out), .dest_out(dest_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic wb, input logic r,
                         input logic w, input logic [31:0] alu, input logic [31:0] rm,
                         input logic [3:0] dest);
        valid_in    = v;
        pc_in       = pc;
        wb_en_in    = wb;
        mem_r_en_in = r;
        mem_w_en_in = w;
        alu_res_in  = alu;
        val_rm_in   = rm;
        dest_in     = dest;
    endtask

    task automatic idle_inputs();
        drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        freeze    = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = 32'd0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle_inputs();
        tick();
        tick();
        checks++;
        if ({valid_out, pc_out, wb_en_out, mem_r_en_out, alu_res_out, mem_data_out, dest_out} !== 103'd0) begin
            errors++;
            $display("FAIL reset_regs: got valid=%b pc=%h alu=%h data=%h dest=%h, expected all 0",
                     valid_out, pc_out, alu_res_out, mem_data_out, dest_out);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({mem_req, mem_stall, mem_we, mem_addr, mem_wdata} !== 67'd0) begin
            errors++;
            $display("FAIL reset_mem_if: got req=%b stall=%b we=%b addr=%h wdata=%h, expected all 0",
                     mem_req, mem_stall, mem_we, mem_addr, mem_wdata);
        end
        tick();
    endtask

    task automatic test_alu();
        drive(1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 32'h55, 32'h0, 4'd3);
        #1;
        checks++;
        if ({mem_req, mem_stall} !== 2'b00) begin
            errors++;
            $display("FAIL alu_no_req: got req=%b stall=%b, expected 0 0", mem_req, mem_stall);
        end
        tick();
        checks++;
        if ({valid_out, wb_en_out, pc_out, alu_res_out, dest_out} !== {1'b1, 1'b1, 32'h100, 32'h55, 4'd3}) begin
            errors++;
            $display("FAIL alu_wb: got v=%b wb=%b pc=%h alu=%h dest=%0d, expected 1 1 100 55 3",
                     valid_out, wb_en_out, pc_out, alu_res_out, dest_out);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_load();
        drive(1'b1, 32'h104, 1'b1, 1'b1, 1'b0, 32'd1032, 32'h0, 4'd5);
        #1;
        checks++;
        if ({mem_req, mem_we, mem_stall, mem_addr} !== {1'b1, 1'b0, 1'b1, 32'd8}) begin
            errors++;
            $display("FAIL load_issue: got req=%b we=%b stall=%b addr=%h, expected 1 0 1 8",
                     mem_req, mem_we, mem_stall, mem_addr);
        end
        tick();
        checks++;
        if (valid_out !== 1'b0) begin
            errors++;
            $display("FAIL load_bubble: got valid_out=%b, expected 0", valid_out);
        end
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEADBEEF;
        #1;
        checks++;
        if ({mem_req, mem_stall, mem_addr} !== {1'b1, 1'b0, 32'd8}) begin
            errors++;
            $display("FAIL load_ack_cycle: got req=%b stall=%b addr=%h, expected 1 0 8", mem_req, mem_stall, mem_addr);
        end
        tick();
        checks++;
        if ({valid_out, mem_r_en_out, mem_data_out, dest_out} !== {1'b1, 1'b1, 32'hDEADBEEF, 4'd5}) begin
            errors++;
            $display("FAIL load_wb: got v=%b r=%b data=%h dest=%0d, expected 1 1 deadbeef 5",
                     valid_out, mem_r_en_out, mem_data_out, dest_out);
        end
        idle_inputs();
        #1;
        checks++;
        if (mem_req !== 1'b0) begin
            errors++;
            $display("FAIL load_no_reissue: got req=%b, expected 0", mem_req);
        end
        tick();
    endtask

    task automatic test_store();
        int bubbles = 0;
        drive(1'b1, 32'h108, 1'b0, 1'b0, 1'b1, 32'd1028, 32'h1234, 4'd0);
        for (int c = 0; c < 7; c++) begin
            mem_ack   = (c == 6);
            mem_rdata = $urandom;
            #1;
            checks++;
            if ({mem_req, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 32'd4, 32'h1234}) begin
                errors++;
                $display("FAIL store_req_stable c=%0d: got req=%b we=%b addr=%h wdata=%h, expected 1 1 4 1234",
                         c, mem_req, mem_we, mem_addr, mem_wdata);
            end
            tick();
            if (c < 6 && valid_out === 1'b0) bubbles++;
        end
        checks++;
        if (bubbles != 6) begin
            errors++;
            $display("FAIL store_bubbles: got %0d, expected 6", bubbles);
        end
        checks++;
        if ({valid_out, wb_en_out, mem_r_en_out, pc_out, mem_data_out} !== {1'b1, 1'b0, 1'b0, 32'h108, 32'd0}) begin
            errors++;
            $display("FAIL store_wb: got v=%b wb=%b r=%b pc=%h data=%h, expected 1 0 0 108 0",
                     valid_out, wb_en_out, mem_r_en_out, pc_out, mem_data_out);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_freeze_ack();
        logic [102:0] snap;
        drive(1'b1, 32'h10C, 1'b1, 1'b1, 1'b0, 32'd1040, 32'h0, 4'd7);
        #1;
        checks++;
        if ({mem_req, mem_addr} !== {1'b1, 32'd16}) begin
            errors++;
            $display("FAIL fz_issue: got req=%b addr=%h, expected 1 10", mem_req, mem_addr);
        end
        tick();
        mem_ack   = 1'b1;
        mem_rdata = 32'hCAFEF00D;
        freeze    = 1'b1;
        #1;
        checks++;
        if (mem_stall !== 1'b0) begin
            errors++;
            $display("FAIL fz_ack_stall: got stall=%b, expected 0", mem_stall);
        end
        snap = {valid_out, pc_out, wb_en_out, mem_r_en_out, alu_res_out, mem_data_out, dest_out};
        tick();
        mem_ack = 1'b0;
        for (int c = 0; c < 4; c++) begin
            checks++;
            if ({valid_out, pc_out, wb_en_out, mem_r_en_out, alu_res_out, mem_data_out, dest_out} !== snap) begin
                errors++;
                $display("FAIL fz_hold c=%0d: got v=%b data=%h, expected v=%b data=%h",
                         c, valid_out, mem_data_out, snap[102], snap[35:4]);
            end
            if (c == 3) break;
            mem_rdata = $urandom;
            #1;
            checks++;
            if (mem_req !== 1'b0) begin
                errors++;
                $display("FAIL fz_done_req c=%0d: got req=%b, expected 0", c, mem_req);
            end
            tick();
        end
        freeze = 1'b0;
        #1;
        checks++;
        if ({mem_req, mem_stall} !== 2'b00) begin
            errors++;
            $display("FAIL fz_release: got req=%b stall=%b, expected 0 0", mem_req, mem_stall);
        end
        tick();
        checks++;
        if ({valid_out, mem_data_out, dest_out} !== {1'b1, 32'hCAFEF00D, 4'd7}) begin
            errors++;
            $display("FAIL fz_wb: got v=%b data=%h dest=%0d, expected 1 cafef00d 7", valid_out, mem_data_out, dest_out);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 32'h200, 1'b1, 1'b0, 1'b0, 32'h77, 32'h0, 4'd9);
        tick();
        drive(1'b1, 32'h204, 1'b1, 1'b1, 1'b0, 32'd1100, 32'h0, 4'd6);
        tick();
        rst = 1'b0;
        idle_inputs();
        tick();
        rst = 1'b1;
        checks++;
        if ({valid_out, pc_out, alu_res_out, mem_data_out, dest_out} !== 101'd0) begin
            errors++;
            $display("FAIL rst_mid_regs: got v=%b pc=%h alu=%h dest=%0d, expected all 0",
                     valid_out, pc_out, alu_res_out, dest_out);
        end
        #1;
        checks++;
        if ({mem_req, mem_stall, mem_we, mem_addr, mem_wdata} !== 67'd0) begin
            errors++;
            $display("FAIL rst_mid_mem_if: got req=%b stall=%b addr=%h, expected 0 0 0", mem_req, mem_stall, mem_addr);
        end
        tick();
        mem_ack   = 1'b1;
        mem_rdata = 32'h5A5A5A5A;
        #1;
        checks++;
        if (mem_req !== 1'b0) begin
            errors++;
            $display("FAIL rst_late_ack_req: got req=%b, expected 0", mem_req);
        end
        tick();
        mem_ack = 1'b0;
        checks++;
        if ({valid_out, mem_data_out} !== 33'd0) begin
            errors++;
            $display("FAIL rst_late_ack_wb: got v=%b data=%h, expected 0 0", valid_out, mem_data_out);
        end
    endtask

    task automatic test_back_to_back();
        int reqs = 0;
        drive(1'b1, 32'h300, 1'b1, 1'b1, 1'b0, 32'd1044, 32'h0, 4'd2);
        #1;
        if (mem_req === 1'b1) reqs++;
        checks++;
        if (mem_stall !== 1'b1) begin
            errors++;
            $display("FAIL b2b_stall: got stall=%b, expected 1", mem_stall);
        end
        tick();
        mem_ack   = 1'b1;
        mem_rdata = 32'h0BADF00D;
        #1;
        if (mem_req === 1'b1) reqs++;
        tick();
        checks++;
        if ({valid_out, pc_out, mem_data_out} !== {1'b1, 32'h300, 32'h0BADF00D}) begin
            errors++;
            $display("FAIL b2b_load: got v=%b pc=%h data=%h, expected 1 300 0badf00d", valid_out, pc_out, mem_data_out);
        end
        mem_ack = 1'b0;
        drive(1'b1, 32'h304, 1'b1, 1'b0, 1'b0, 32'hABC, 32'h0, 4'd4);
        #1;
        if (mem_req === 1'b1) reqs++;
        tick();
        checks++;
        if ({valid_out, pc_out, alu_res_out, mem_data_out, dest_out} !== {1'b1, 32'h304, 32'hABC, 32'd0, 4'd4}) begin
            errors++;
            $display("FAIL b2b_alu: got v=%b pc=%h alu=%h data=%h dest=%0d, expected 1 304 abc 0 4",
                     valid_out, pc_out, alu_res_out, mem_data_out, dest_out);
        end
        checks++;
        if (reqs != 2) begin
            errors++;
            $display("FAIL b2b_req_cycles: got %0d, expected 2", reqs);
        end
        idle_inputs();
        tick();
    endtask

    // Reference: in-order EX/MEM stream that advances whenever the stage is neither stalled nor frozen,
    // backed by a word-addressed memory with random ack latency.
    task automatic test_random();
        instr_t      prog[$];
        instr_t      t;
        instr_t      nop;
        logic [31:0] dmem [64];
        int          n = 60;
        int          cur = 0;
        int          cyc = 0;
        int          wait_cnt = 0;
        int          kind;
        int          req_idx = 0;
        logic        pending = 1'b0;
        logic        served = 1'b0;
        logic        fz, ack, memop, exp_req, exp_stall, new_issue, advance;
        logic [31:0] req_addr = 32'd0, req_wdata = 32'd0, acc_data = 32'd0, exp_addr, exp_data;
        logic        req_we = 1'b0;
        logic [102:0] snap;

        nop = '{v: 1'b0, pc: 32'd0, wb: 1'b0, r: 1'b0, w: 1'b0, alu: 32'd0, rm: 32'd0, dest: 4'd0};
        for (int i = 0; i < 64; i++) dmem[i] = $urandom;
        for (int i = 0; i < n; i++) begin
            kind   = int'($urandom_range(0, 3));
            t.v    = (kind != 0);
            t.pc   = 32'h1000 + 32'(4 * i);
            t.rm   = $urandom;
            t.dest = 4'($urandom_range(0, 15));
            t.alu  = (kind == 1) ? $urandom : 32'd1024 + $urandom_range(0, 255);
            t.r    = (kind == 2) || (kind == 0 && $urandom_range(0, 1) == 32'd1);
            t.w    = (kind == 3) || ((kind == 0 || kind == 2) && $urandom_range(0, 1) == 32'd1);
            t.wb   = (kind == 1 || kind == 2);
            prog.push_back(t);
        end

        while ((cur < n || pending || served) && cyc < 4000) begin
            t = (cur < n) ? prog[cur] : nop;
            fz  = ($urandom_range(0, 3) == 32'd0);
            ack = pending && (wait_cnt == 0);
            drive(t.v, t.pc, t.wb, t.r, t.w, t.alu, t.rm, t.dest);
            freeze    = fz;
            mem_ack   = ack;
            mem_rdata = ack ? dmem[req_idx] : $urandom;
            memop     = t.v & (t.r | t.w);
            exp_addr  = (t.alu - 32'd1024) & ~32'd3;
            exp_req   = served ? 1'b0 : (pending ? 1'b1 : (memop & ~fz));
            exp_stall = pending ? ~ack : (served ? 1'b0 : memop);
            new_issue = ~pending & ~served & memop & ~fz;
            #1;
            checks++;
            if ({mem_req, mem_stall} !== {exp_req, exp_stall}) begin
                errors++;
                $display("FAIL rnd_req_stall cyc=%0d: got req=%b stall=%b, expected %b %b",
                         cyc, mem_req, mem_stall, exp_req, exp_stall);
            end
            if (new_issue) begin
                req_addr  = exp_addr;
                req_we    = t.w & ~t.r;
                req_wdata = t.rm;
                req_idx   = int'(exp_addr[7:2]);
            end
            if (pending || new_issue) begin
                checks++;
                if ({mem_addr, mem_we} !== {req_addr, req_we} || (req_we && mem_wdata !== req_wdata)) begin
                    errors++;
                    $display("FAIL rnd_req_fields cyc=%0d: got addr=%h we=%b wdata=%h, expected %h %b %h",
                             cyc, mem_addr, mem_we, mem_wdata, req_addr, req_we, req_wdata);
                end
            end
            if (ack) acc_data = req_we ? 32'd0 : dmem[req_idx];
            snap = {valid_out, pc_out, wb_en_out, mem_r_en_out, alu_res_out, mem_data_out, dest_out};
            tick();
            if (ack) begin
                if (req_we) dmem[req_idx] = req_wdata;
                pending = 1'b0;
                served  = 1'b1;
            end else if (pending) begin
                wait_cnt--;
            end
            if (new_issue) begin
                pending  = 1'b1;
                wait_cnt = int'($urandom_range(0, 3));
            end
            advance  = ~fz & ~exp_stall;
            exp_data = memop ? acc_data : 32'd0;
            checks++;
            if (fz) begin
                if ({valid_out, pc_out, wb_en_out, mem_r_en_out, alu_res_out, mem_data_out, dest_out} !== snap) begin
                    errors++;
                    $display("FAIL rnd_freeze_hold cyc=%0d: got v=%b pc=%h, expected v=%b pc=%h",
                             cyc, valid_out, pc_out, snap[102], snap[101:70]);
                end
            end else if (advance && t.v) begin
                if ({valid_out, pc_out, wb_en_out, mem_r_en_out, alu_res_out, mem_data_out, dest_out} !==
                    {1'b1, t.pc, t.wb, t.r, t.alu, exp_data, t.dest}) begin
                    errors++;
                    $display("FAIL rnd_wb cyc=%0d: got v=%b pc=%h wb=%b r=%b alu=%h data=%h dest=%0d, expected 1 %h %b %b %h %h %0d",
                             cyc, valid_out, pc_out, wb_en_out, mem_r_en_out, alu_res_out, mem_data_out, dest_out,
                             t.pc, t.wb, t.r, t.alu, exp_data, t.dest);
                end
            end else begin
                if ({valid_out, wb_en_out, mem_r_en_out} !== 3'b000) begin
                    errors++;
                    $display("FAIL rnd_bubble cyc=%0d: got v=%b wb=%b r=%b, expected 0 0 0",
                             cyc, valid_out, wb_en_out, mem_r_en_out);
                end
            end
            if (advance) begin
                if (cur < n) cur++;
                served = 1'b0;
            end
            cyc++;
        end
        checks++;
        if (cyc >= 4000) begin
            errors++;
            $display("FAIL rnd_timeout: got %0d of %0d instructions retired, expected all", cur, n);
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_freeze_ack();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
